// File: rtl/wb_ram_slave.sv
// Wishbone classic responder with a 16-bit word RAM window and a small I/O bank.
// The two spaces are selected by the address tag. Every transfer passes through
// an IDLE -> [WAIT] -> ACK sequence, and the ack lasts exactly one cycle.
module wb_ram_slave #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        sys_rst_n,
  input  logic [19:1] wbs_adr_i,
  input  logic [15:0] wbs_dat_i,
  output logic [15:0] wbs_dat_o,
  input  logic [1:0]  wbs_sel_i,
  input  logic        wbs_tga_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o
);

  localparam int          DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES - 1);
  localparam logic [15:0] ID_WORD = {8'h5A, 4'(WAIT_STATES), 4'(ADDR_BITS)};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wcnt_reg, wcnt_next;
  logic        latch_en;
  logic        commit;

  logic [19:1] adr_reg;
  logic [15:0] dat_reg;
  logic [1:0]  sel_reg;
  logic        we_reg;
  logic        tga_reg;

  logic        ack_reg;
  logic [15:0] dat_o_reg;
  logic [15:0] count_reg;

  logic [15:0] mem [0:DEPTH-1];

  logic        req;
  logic        in_idle;
  logic [19:1] cur_adr;
  logic [15:0] cur_dat;
  logic [1:0]  cur_sel;
  logic        cur_we;
  logic        cur_tga;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [1:0]  io_sel;
  logic [15:0] wr_mask;
  logic [15:0] io_rd;
  logic        unused_adr;

  assign req     = wbs_stb_i & wbs_cyc_i;
  assign in_idle = (state_reg == S_IDLE);

  // With zero wait states the commit edge is the sampling edge itself, so the
  // live bus fields are used in IDLE and the latched copies everywhere else.
  assign cur_adr = in_idle ? wbs_adr_i : adr_reg;
  assign cur_dat = in_idle ? wbs_dat_i : dat_reg;
  assign cur_sel = in_idle ? wbs_sel_i : sel_reg;
  assign cur_we  = in_idle ? wbs_we_i  : we_reg;
  assign cur_tga = in_idle ? wbs_tga_i : tga_reg;

  assign mem_idx    = cur_adr[ADDR_BITS:1];
  assign io_sel     = cur_adr[2:1];
  assign wr_mask    = {{8{cur_sel[1]}}, {8{cur_sel[0]}}};
  assign unused_adr = ^cur_adr[19:ADDR_BITS+1];

  // State, wait counter and ack register.
  always_ff @(posedge wb_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= S_IDLE;
      wcnt_reg  <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      ack_reg   <= commit;
    end
  end

  // Next-state logic; commit marks the edge that enters ACK.
  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    latch_en   = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = S_ACK;
            commit     = 1'b1;
          end else begin
            wcnt_next  = WS_INIT;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          // Master gave up: drop back silently, counter left as-is.
          state_next = S_IDLE;
        end else if (wcnt_reg == 4'd0) begin
          state_next = S_ACK;
          commit     = 1'b1;
        end else begin
          wcnt_next = wcnt_reg - 4'd1;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Capture the request fields when a transfer is accepted in IDLE.
  always_ff @(posedge wb_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      adr_reg <= '0;
      dat_reg <= '0;
      sel_reg <= '0;
      we_reg  <= 1'b0;
      tga_reg <= 1'b0;
    end else if (latch_en) begin
      adr_reg <= wbs_adr_i;
      dat_reg <= wbs_dat_i;
      sel_reg <= wbs_sel_i;
      we_reg  <= wbs_we_i;
      tga_reg <= wbs_tga_i;
    end
  end

  // Byte-masked RAM write on the commit edge; contents are never reset.
  always_ff @(posedge wb_clk_i) begin
    if (commit && cur_we && !cur_tga) begin
      for (int b = 0; b < 2; b++) begin
        if (cur_sel[b]) begin
          mem[mem_idx][b*8 +: 8] <= cur_dat[b*8 +: 8];
        end
      end
    end
  end

  // Two byte-writable scratch registers in the I/O bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_scratch
    logic [15:0] scratch_reg;

    // Update this scratch register when an I/O write targets it.
    always_ff @(posedge wb_clk_i or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        scratch_reg <= '0;
      end else if (commit && cur_tga && cur_we && io_sel == 2'(gi)) begin
        scratch_reg <= (scratch_reg & ~wr_mask) | (cur_dat & wr_mask);
      end
    end
  end

  // I/O bank read decode.
  always_comb begin
    io_rd = 16'h0000;
    case (io_sel)
      2'd0:    io_rd = g_scratch[0].scratch_reg;
      2'd1:    io_rd = g_scratch[1].scratch_reg;
      2'd2:    io_rd = count_reg;
      default: io_rd = ID_WORD;
    endcase
  end

  // Access counter: memory transfers count up, any I/O write to slot 2 clears.
  always_ff @(posedge wb_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_reg <= '0;
    end else if (commit) begin
      if (!cur_tga) begin
        count_reg <= count_reg + 16'd1;
      end else if (cur_we && io_sel == 2'd2) begin
        count_reg <= '0;
      end
    end
  end

  // Read data register: loaded only by read commits, held across writes.
  always_ff @(posedge wb_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dat_o_reg <= '0;
    end else if (commit && !cur_we) begin
      dat_o_reg <= cur_tga ? io_rd : mem[mem_idx];
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_o_reg;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: directed table, multi-cycle corner
// sequences and randomized traffic checked against an array-based model.
module tb_wb_ram_slave;

  localparam int AB = 10;
  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:1] adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic [1:0]  sel;
  logic        tga, stb, cyc, we;
  logic        ack;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] m_mem [0:(1<<AB)-1];
  logic [15:0] m_scr [0:1];
  logic [15:0] m_cnt;
  logic [15:0] m_last;

  always #5 clk = ~clk;

  wb_ram_slave #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .wb_clk_i (clk),
    .sys_rst_n(rst_n),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o),
    .wbs_sel_i(sel),
    .wbs_tga_i(tga),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_ack_o(ack)
  );

  typedef struct {
    logic        tga;
    logic        we;
    logic [19:1] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        has_exp;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = nw[7:0];
    if (s[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  function automatic logic [15:0] m_read(input logic t, input logic [19:1] a);
    logic [AB-1:0] idx;
    idx = a[AB:1];
    if (!t) return m_mem[idx];
    case (a[2:1])
      2'd0:    return m_scr[0];
      2'd1:    return m_scr[1];
      2'd2:    return m_cnt;
      default: return {8'h5A, 4'(WS), 4'(AB)};
    endcase
  endfunction

  task automatic m_commit(input logic t, input logic w, input logic [19:1] a,
                          input logic [15:0] d, input logic [1:0] s);
    logic [AB-1:0] idx;
    idx = a[AB:1];
    if (!t) begin
      m_cnt = m_cnt + 16'd1;
      if (w) m_mem[idx] = merge(m_mem[idx], d, s);
    end else if (w) begin
      case (a[2:1])
        2'd0:    m_scr[0] = merge(m_scr[0], d, s);
        2'd1:    m_scr[1] = merge(m_scr[1], d, s);
        2'd2:    m_cnt = 16'h0000;
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    m_scr[0] = '0;
    m_scr[1] = '0;
    m_cnt    = '0;
    m_last   = '0;
  endtask

  // One full transfer: checks latency, read data vs model, data hold on
  // writes and the single-cycle ack, then updates the model.
  task automatic xact(input logic t, input logic w, input logic [19:1] a,
                      input logic [15:0] d, input logic [1:0] s,
                      output logic [15:0] rd);
    int  lat;
    bit  ok;
    logic [15:0] exp;
    @(posedge clk); #1;
    tga = t; we = w; adr = a; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin
        ok = 1'b1;
        break;
      end
    end
    rd  = dat_o;
    stb = 1'b0;
    cyc = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      rd = 'x;
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
      return;
    end
    exp = m_read(t, a);
    $display("[TB] xact tga=%0d we=%0d adr=%h dat=%h sel=%b -> dat_o=%h lat=%0d",
             t, w, a, d, s, rd, lat);
    chk("latency", 16'(lat), 16'(WS + 1));
    if (!w) begin
      chk("read_data", rd, exp);
      m_last = exp;
    end else begin
      chk("dat_hold", rd, m_last);
    end
    m_commit(t, w, a, d, s);
    @(posedge clk); #1;
    chk("ack_pulse", {15'd0, ack}, 16'h0000);
  endtask

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic [19:1] a;
    int acks, last;
    bit saw;

    tbl[0]  = '{1'b1, 1'b0, 19'd0, 16'h0000, 2'b11, 1'b1, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 19'd1, 16'h0000, 2'b11, 1'b1, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 19'd3, 16'h0000, 2'b11, 1'b1, 16'h5A1A};
    tbl[4]  = '{1'b0, 1'b1, 19'd5, 16'hBEEF, 2'b11, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 19'd5, 16'h0000, 2'b00, 1'b1, 16'hBEEF};
    tbl[6]  = '{1'b0, 1'b1, 19'd7, 16'h1234, 2'b01, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 19'd7, 16'hAB00, 2'b10, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 19'd7, 16'h0000, 2'b11, 1'b1, 16'hAB34};
    tbl[9]  = '{1'b0, 1'b1, 19'd7, 16'hFFFF, 2'b00, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 19'd7, 16'h0000, 2'b11, 1'b1, 16'hAB34};
    tbl[11] = '{1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, 1'b1, 16'h0007};
    tbl[12] = '{1'b1, 1'b1, 19'd2, 16'h0000, 2'b00, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, 1'b1, 16'h0000};
    tbl[14] = '{1'b1, 1'b1, 19'd1, 16'hA5C3, 2'b10, 1'b0, 16'h0000};
    tbl[15] = '{1'b1, 1'b0, 19'd1, 16'h0000, 2'b11, 1'b1, 16'hA500};
    tbl[16] = '{1'b1, 1'b1, 19'd3, 16'hFFFF, 2'b11, 1'b0, 16'h0000};
    tbl[17] = '{1'b1, 1'b0, 19'd3, 16'h0000, 2'b11, 1'b1, 16'h5A1A};
    tbl[18] = '{1'b1, 1'b1, 19'h7FFC, 16'h1234, 2'b01, 1'b0, 16'h0000};
    tbl[19] = '{1'b1, 1'b0, 19'd0, 16'h0000, 2'b11, 1'b1, 16'h0034};

    // Reset
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; tga = 1'b0;
    adr = '0; dat_i = '0; sel = '0;
    for (int i = 0; i < (1 << AB); i++) m_mem[i] = 'x;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {15'd0, ack}, 16'h0000);
    chk("rst_dat_o", dat_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", {15'd0, ack}, 16'h0000);
    chk("post_rst_dat_o", dat_o, 16'h0000);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      xact(tbl[i].tga, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
      if (tbl[i].has_exp) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // Back-to-back: strobe held across three reads
    xact(1'b1, 1'b1, 19'd2, 16'h0000, 2'b11, rd);
    @(posedge clk); #1;
    tga = 1'b0; we = 1'b0; adr = 19'd5; sel = 2'b11; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    last = -1;
    for (int c = 0; c < 30 && acks < 3; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        chk("b2b_data", dat_o, 16'hBEEF);
        if (last >= 0) chk("b2b_spacing", 16'(c - last), 16'(WS + 2));
        last = c;
        m_cnt = m_cnt + 16'd1;
      end
    end
    stb = 1'b0; cyc = 1'b0;
    m_last = 16'hBEEF;
    chk("b2b_acks", 16'(acks), 16'd3);
    @(posedge clk); #1;
    chk("b2b_no_extra", {15'd0, ack}, 16'h0000);
    xact(1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, rd);
    chk("b2b_count", rd, 16'd3);
    xact(1'b1, 1'b1, 19'd2, 16'h0000, 2'b01, rd);
    xact(1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, rd);
    chk("count_clear", rd, 16'd0);

    // Abort in WAIT
    xact(1'b0, 1'b1, 19'd9, 16'h0000, 2'b11, rd);
    @(posedge clk); #1;
    tga = 1'b0; we = 1'b1; adr = 19'd9; dat_i = 16'h5555; sel = 2'b11; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) saw = 1'b1;
    end
    chk("abort_noack", {15'd0, saw}, 16'h0000);
    xact(1'b0, 1'b0, 19'd9, 16'h0000, 2'b11, rd);
    chk("abort_word9", rd, 16'h0000);
    xact(1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, rd);
    chk("abort_count", rd, 16'd2);

    // Counter wrap
    @(posedge clk); #1;
    force dut.count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.count_reg;
    m_cnt = 16'hFFFF;
    xact(1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, rd);
    xact(1'b0, 1'b0, 19'd5, 16'h0000, 2'b11, rd);
    xact(1'b1, 1'b0, 19'd2, 16'h0000, 2'b11, rd);
    chk("count_wrap", rd, 16'h0000);

    // Address aliasing above ADDR_BITS
    a = 19'd11;
    a[AB+1] = 1'b1;
    xact(1'b0, 1'b1, a, 16'h7E57, 2'b11, rd);
    xact(1'b0, 1'b0, 19'd11, 16'h0000, 2'b11, rd);
    chk("alias", rd, 16'h7E57);

    // Reset while a write waits: nothing committed
    xact(1'b0, 1'b1, 19'd3, 16'h2222, 2'b11, rd);
    @(posedge clk); #1;
    tga = 1'b0; we = 1'b1; adr = 19'd3; dat_i = 16'h9999; sel = 2'b11; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ack", {15'd0, ack}, 16'h0000);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_ack2", {15'd0, ack}, 16'h0000);
    rst_n = 1'b1;
    m_reset();
    xact(1'b0, 1'b0, 19'd3, 16'h0000, 2'b11, rd);
    chk("rst_wait_nowrite", rd, 16'h2222);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, 1'b1, 19'(i), 16'($urandom), 2'b11, rd);
    end
    for (int i = 0; i < 60; i++) begin
      logic t, w;
      logic [1:0] s;
      t = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = 19'($urandom);
      if (!t) a[AB:1] = AB'($urandom_range(0, 15));
      xact(t, w, a, 16'($urandom), s, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
